reg_cmd_feeder: RTL and testbench
=================================

Name: reg_cmd_feeder

Overview:
- Upstream command stage for register_4bit; produces its load, j and i inputs.
- Accepts packed commands {load, j[1:0], i[DW-1:0]} from a producer over a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Issues at most one command per clock, in order, onto registered outputs wired directly to register_4bit.
- Outputs an idle command (all zeros) whenever nothing is issued.

Parameters:
- DW, 4, data width of the i field; command width is DW+3.
- DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  producer presents a command on in_cmd.
- in_cmd  input  DW+3  {load, j[1:0], i[DW-1:0]}; load is the MSB, i is the LSBs.
- in_ready  output  1  feeder can accept a command this cycle.
- issue_en  input  1  downstream permits issuing this cycle.
- load  output  1  load strobe to register_4bit.
- j  output  2  mode select to register_4bit.
- i  output  DW  data to register_4bit.
- issued  output  1  high for the cycle in which load/j/i carry a popped command.
- count  output  clog2(DEPTH)+1  number of entries currently held.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.

Behaviour:
- Reset (reset high at a rising edge):
  - Read pointer, write pointer and count cleared to 0.
  - load=0, j=2'b00, i=0, issued=0, empty=1, full=0.
  - Any push or pop in that cycle is ignored.
  - in_ready is 0 while reset is high and 1 in the first cycle after reset deasserts.
- Reset mid-operation: all buffered commands are discarded; no partial or late issue after reset.
- in_ready = ~full & ~reset. It does not depend combinationally on issue_en or the pop.
- Push: in_valid & in_ready at a rising edge writes in_cmd at the write pointer; write pointer advances modulo DEPTH.
- Pop: issue_en & ~empty at a rising edge reads the head entry.
  - The entry's fields are registered onto load/j/i and issued is set to 1.
  - Read pointer advances modulo DEPTH.
- Latency: a command popped at edge N appears on load/j/i from edge N through edge N+1. Minimum push-to-output latency is 2 edges.
- No bypass: a command pushed while empty cannot pop in the same cycle. It is eligible from the next edge.
- No issue (issue_en=0, or empty): at the next edge load=0, j=2'b00, i=0, issued=0. The register therefore sees a hold/no-op command, never a stale repeat.
- Push and pop in the same edge: count unchanged; both pointers advance.
  - Legal when full: a pop occurs, but no push because in_ready=0.
  - Legal when empty: a push occurs, but no pop because of the no-bypass rule.
- count updates at the same edge as the push/pop. empty and full are derived combinationally from the registered count.
- Pointer wrap: entries are issued strictly in push order across the DEPTH-1 to 0 wrap.
- Overflow and underflow cannot occur by construction. A push attempted with in_ready=0 is dropped and is the producer's responsibility.
- j and i values are passed through unmodified. The feeder does not interpret the mode encoding.

Test Plan:
- Reset then idle: reset high 2 cycles, then issue_en=1 with no pushes → load/j/i=0, issued=0, count=0, empty=1, in_ready=1 throughout.
- Single command: push 7'b1_01_0110 (load=1, j=01, i=4'h6) with issue_en=1 → output appears 2 edges after the push: load=1, j=01, i=6, issued=1 for one cycle, then zeros.
- Fill and backpressure: issue_en=0, push 4'h9, 4'hA, 4'hB, 4'hC and attempt a fifth push (4'hD).
  - After four pushes: count=4, full=1, in_ready=0.
  - The 4'hD command is dropped.
  - With issue_en=1, outputs 9, A, B, C follow on consecutive cycles.
- Simultaneous push/pop at full: while count=4, hold issue_en=1 and in_valid=1.
  - Count goes 4→3 at the first edge (pop only).
  - At later edges count holds at 3 as push and pop coincide.
  - Order is preserved.
- Wrap-around: stream 10 commands i=0..9 through with issue_en toggling 1,0,1,0 → outputs in exact order 0..9, with a zero idle cycle after each issued cycle.
- Reset mid-stream: with count=3 (i=5, 6, 7 held), assert reset for one edge → count=0 and outputs zero. After release, no 5/6/7 ever appears on i, and a new push of 4'h8 is issued normally.

Source files
------------

// File: rtl/reg_cmd_feeder_if.sv
// Command bus between a producer, the reg_cmd_feeder and the register_4bit it drives.
// The slave modport is the feeder's view; master is the producer/downstream view.
interface reg_cmd_feeder_if #(
    parameter int DW    = 4,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          in_valid;
    logic [DW+2:0] in_cmd;
    logic          in_ready;
    logic          issue_en;
    logic          load;
    logic [1:0]    j;
    logic [DW-1:0] i;
    logic          issued;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;

    modport slave (
        input  in_valid, in_cmd, issue_en,
        output in_ready, load, j, i, issued, count, empty, full
    );

    modport master (
        output in_valid, in_cmd, issue_en,
        input  in_ready, load, j, i, issued, count, empty, full
    );
endinterface

// File: rtl/reg_cmd_feeder.sv
// Buffers {load, j, i} commands in a small FIFO and issues at most one per clock
// onto registered outputs for register_4bit; idle cycles present an all-zero command.
module reg_cmd_feeder #(
    parameter int DW    = 4,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    reg_cmd_feeder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW+2:0] mem_q [DEPTH];
    logic [AW-1:0] wrPtr_q, wrPtr_d;
    logic [AW-1:0] rdPtr_q, rdPtr_d;
    logic [CW-1:0] count_q, count_d;
    logic          load_q, load_d;
    logic [1:0]    j_q, j_d;
    logic [DW-1:0] i_q, i_d;
    logic          issued_q, issued_d;

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [DW+2:0] head;

    // Pop looks only at the registered count, so a command pushed into an empty FIFO waits one edge.
    assign full         = (count_q == CW'(DEPTH));
    assign empty        = (count_q == '0);
    assign bus.in_ready = ~full & ~reset;
    assign push         = bus.in_valid & bus.in_ready;
    assign pop          = bus.issue_en & ~empty;
    assign head         = mem_q[rdPtr_q];

    always_comb begin
        wrPtr_d  = wrPtr_q;
        rdPtr_d  = rdPtr_q;
        count_d  = count_q;
        load_d   = 1'b0;
        j_d      = 2'b00;
        i_d      = '0;
        issued_d = 1'b0;
        if (push) begin
            wrPtr_d = wrPtr_q + AW'(1);
        end
        if (pop) begin
            rdPtr_d                = rdPtr_q + AW'(1);
            {load_d, j_d, i_d}     = head;
            issued_d               = 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr_q  <= '0;
            rdPtr_q  <= '0;
            count_q  <= '0;
            load_q   <= 1'b0;
            j_q      <= 2'b00;
            i_q      <= '0;
            issued_q <= 1'b0;
        end else begin
            wrPtr_q  <= wrPtr_d;
            rdPtr_q  <= rdPtr_d;
            count_q  <= count_d;
            load_q   <= load_d;
            j_q      <= j_d;
            i_q      <= i_d;
            issued_q <= issued_d;
        end
    end

    // Storage needs no reset: push is already blocked while reset is high.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wrPtr_q] <= bus.in_cmd;
        end
    end

    assign bus.load   = load_q;
    assign bus.j      = j_q;
    assign bus.i      = i_q;
    assign bus.issued = issued_q;
    assign bus.count  = count_q;
    assign bus.empty  = empty;
    assign bus.full   = full;
endmodule

// File: tb/tb_reg_cmd_feeder.sv
// Directed vector table for reg_cmd_feeder plus a streamed wrap-around sequence
// checked against a queue model.
module tb_reg_cmd_feeder;
    localparam int DW    = 4;
    localparam int DEPTH = 4;

    typedef struct {
        logic       rst;
        logic       inValid;
        logic [6:0] inCmd;
        logic       issueEn;
        logic       expLoad;
        logic [1:0] expJ;
        logic [3:0] expI;
        logic       expIssued;
        int         expCount;
        logic       expReady;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];

    reg_cmd_feeder_if #(.DW(DW), .DEPTH(DEPTH)) bus ();

    reg_cmd_feeder #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic addVec(input logic r, input logic v, input logic [6:0] c, input logic e,
                          input logic l, input logic [1:0] jj, input logic [3:0] ii,
                          input logic iss, input int cnt, input logic rdy);
        vec_t t;
        t.rst = r; t.inValid = v; t.inCmd = c; t.issueEn = e;
        t.expLoad = l; t.expJ = jj; t.expI = ii; t.expIssued = iss;
        t.expCount = cnt; t.expReady = rdy;
        vecs.push_back(t);
    endtask

    task automatic applyStimulus(input logic r, input logic v, input logic [6:0] c, input logic e);
        reset        = r;
        bus.in_valid = v;
        bus.in_cmd   = c;
        bus.issue_en = e;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkVector(input int k, input vec_t t);
        checkOutput($sformatf("v%0d.load", k),     32'(bus.load),     32'(t.expLoad));
        checkOutput($sformatf("v%0d.j", k),        32'(bus.j),        32'(t.expJ));
        checkOutput($sformatf("v%0d.i", k),        32'(bus.i),        32'(t.expI));
        checkOutput($sformatf("v%0d.issued", k),   32'(bus.issued),   32'(t.expIssued));
        checkOutput($sformatf("v%0d.count", k),    32'(bus.count),    32'(t.expCount));
        checkOutput($sformatf("v%0d.empty", k),    32'(bus.empty),    32'(t.expCount == 0));
        checkOutput($sformatf("v%0d.full", k),     32'(bus.full),     32'(t.expCount == DEPTH));
        checkOutput($sformatf("v%0d.in_ready", k), 32'(bus.in_ready), 32'(t.expReady));
    endtask

    initial begin
        int         mCount;
        int         sent;
        int         got;
        logic [6:0] expQ[$];
        logic [6:0] cmd;
        logic [6:0] expCmd;
        logic       en;
        logic       pushOk;
        logic       popOk;

        bus.in_valid = 1'b0;
        bus.in_cmd   = '0;
        bus.issue_en = 1'b0;

        //     rst v  cmd          en   ld j      i     iss cnt rdy
        addVec(1, 0, 7'b0000000, 0,   0, 2'b00, 4'h0, 0,  0,  0);
        addVec(1, 0, 7'b0000000, 0,   0, 2'b00, 4'h0, 0,  0,  0);
        addVec(0, 0, 7'b0000000, 1,   0, 2'b00, 4'h0, 0,  0,  1);
        addVec(0, 0, 7'b0000000, 1,   0, 2'b00, 4'h0, 0,  0,  1);
        addVec(0, 1, 7'b1010110, 1,   0, 2'b00, 4'h0, 0,  1,  1);
        addVec(0, 0, 7'b0000000, 1,   1, 2'b01, 4'h6, 1,  0,  1);
        addVec(0, 0, 7'b0000000, 1,   0, 2'b00, 4'h0, 0,  0,  1);
        addVec(0, 1, 7'b0111001, 0,   0, 2'b00, 4'h0, 0,  1,  1);
        addVec(0, 1, 7'b1001010, 0,   0, 2'b00, 4'h0, 0,  2,  1);
        addVec(0, 1, 7'b1101011, 0,   0, 2'b00, 4'h0, 0,  3,  1);
        addVec(0, 1, 7'b0011100, 0,   0, 2'b00, 4'h0, 0,  4,  0);
        addVec(0, 1, 7'b1111101, 0,   0, 2'b00, 4'h0, 0,  4,  0);
        addVec(0, 1, 7'b1111110, 1,   0, 2'b11, 4'h9, 1,  3,  1);
        addVec(0, 1, 7'b1111110, 1,   1, 2'b00, 4'hA, 1,  3,  1);
        addVec(0, 1, 7'b0101111, 1,   1, 2'b10, 4'hB, 1,  3,  1);
        addVec(0, 0, 7'b0000000, 1,   0, 2'b01, 4'hC, 1,  2,  1);
        addVec(0, 0, 7'b0000000, 1,   1, 2'b11, 4'hE, 1,  1,  1);
        addVec(0, 0, 7'b0000000, 0,   0, 2'b00, 4'h0, 0,  1,  1);
        addVec(0, 0, 7'b0000000, 1,   0, 2'b10, 4'hF, 1,  0,  1);
        addVec(0, 0, 7'b0000000, 1,   0, 2'b00, 4'h0, 0,  0,  1);
        addVec(0, 1, 7'b1010101, 0,   0, 2'b00, 4'h0, 0,  1,  1);
        addVec(0, 1, 7'b1010110, 0,   0, 2'b00, 4'h0, 0,  2,  1);
        addVec(0, 1, 7'b1010111, 0,   0, 2'b00, 4'h0, 0,  3,  1);
        addVec(1, 1, 7'b0000111, 1,   0, 2'b00, 4'h0, 0,  0,  0);
        addVec(0, 0, 7'b0000000, 1,   0, 2'b00, 4'h0, 0,  0,  1);
        addVec(0, 0, 7'b0000000, 1,   0, 2'b00, 4'h0, 0,  0,  1);
        addVec(0, 1, 7'b1001000, 1,   0, 2'b00, 4'h0, 0,  1,  1);
        addVec(0, 0, 7'b0000000, 1,   1, 2'b00, 4'h8, 1,  0,  1);
        addVec(0, 0, 7'b0000000, 1,   0, 2'b00, 4'h0, 0,  0,  1);

        foreach (vecs[k]) begin
            applyStimulus(vecs[k].rst, vecs[k].inValid, vecs[k].inCmd, vecs[k].issueEn);
            checkVector(k, vecs[k]);
        end

        // Stream i=0..9 with issue_en toggling so the pointers wrap twice.
        mCount = 0;
        sent   = 0;
        got    = 0;
        for (int cyc = 0; cyc < 100 && got < 10; cyc++) begin
            en     = (cyc % 2 == 0);
            cmd    = {1'b1, 2'(sent % 4), 4'(sent)};
            pushOk = (sent < 10) && (mCount < DEPTH);
            popOk  = en && (mCount > 0);
            checkOutput("wrap.in_ready", 32'(bus.in_ready), 32'(mCount < DEPTH));
            applyStimulus(1'b0, sent < 10, cmd, en);
            if (pushOk) begin
                expQ.push_back(cmd);
                sent++;
            end
            if (popOk) begin
                expCmd = expQ.pop_front();
                checkOutput("wrap.cmd", 32'({bus.load, bus.j, bus.i}), 32'(expCmd));
                checkOutput("wrap.issued", 32'(bus.issued), 32'(1));
                got++;
            end else begin
                checkOutput("wrap.idle", 32'({bus.load, bus.j, bus.i}), 32'(0));
                checkOutput("wrap.noissue", 32'(bus.issued), 32'(0));
            end
            mCount = mCount + int'(pushOk) - int'(popOk);
            checkOutput("wrap.count", 32'(bus.count), 32'(mCount));
        end
        checks++;
        if (got < 10) begin
            errors++;
            $display("[TB] FAIL wrap.timeout: got %0d commands expected 10", got);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
